stream_extremum: RTL and testbench

Streaming successor to the team's 8-bit signed max comparator: a parametrised block that scans a frame of up to LEN samples over a valid/ready stream and reports the extremum (max or min, signed or unsigned) with its index and the frame's sample count. It sits between a sample producer and a result consumer in the datapath. Each frame's mode is latched on its first sample.

---
 rtl/stream_extremum.sv | 105 ++++++++++
 tb/tb_stream_extremum.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/stream_extremum.sv
// rtl/stream_extremum.sv - streaming max/min finder with index and count per frame
module stream_extremum #(
  parameter int WIDTH = 8,
  parameter int LEN   = 16,
  parameter int IDX_W = $clog2(LEN),
  parameter int CNT_W = $clog2(LEN + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_last,
  input  logic             find_min,
  input  logic             is_signed,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_value,
  output logic [IDX_W-1:0] out_index,
  output logic [CNT_W-1:0] out_count
);

  typedef enum logic {ACCUM, HOLD} state_t;

  state_t           state, state_next;
  logic [CNT_W-1:0] count;
  logic [WIDTH-1:0] best;
  logic [IDX_W-1:0] best_idx;
  logic             mode_min, mode_signed;

  logic             accept, first, frame_end, cur_min, cur_signed, better;
  logic [WIDTH-1:0] new_best;
  logic [IDX_W-1:0] new_idx;

  // Strict a > b; signed case decides on sign bits, then magnitude bits.
  function automatic logic greater(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                   input logic sgn);
    if (sgn && (a[WIDTH-1] != b[WIDTH-1]))
      greater = ~a[WIDTH-1];
    else if (sgn)
      greater = a[WIDTH-2:0] > b[WIDTH-2:0];
    else
      greater = a > b;
  endfunction

  assign in_ready   = (state == ACCUM);
  assign out_valid  = (state == HOLD);
  assign accept     = in_valid & in_ready;
  assign first      = (count == '0);
  assign cur_min    = first ? find_min  : mode_min;
  assign cur_signed = first ? is_signed : mode_signed;
  assign better     = cur_min ? greater(best, in_data, cur_signed)
                              : greater(in_data, best, cur_signed);
  assign new_best   = (first || better) ? in_data : best;
  assign new_idx    = first ? '0 : (better ? count[IDX_W-1:0] : best_idx);
  assign frame_end  = accept & (in_last | (count == CNT_W'(LEN - 1)));

  always_ff @(posedge clk) begin
    if (!rst_n)
      state <= ACCUM;
    else
      state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      ACCUM: if (frame_end) state_next = HOLD;
      HOLD:  if (out_ready) state_next = ACCUM;
      default: state_next = ACCUM;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count       <= '0;
      best        <= '0;
      best_idx    <= '0;
      mode_min    <= 1'b0;
      mode_signed <= 1'b0;
      out_value   <= '0;
      out_index   <= '0;
      out_count   <= '0;
    end else begin
      if (accept) begin
        best     <= new_best;
        best_idx <= new_idx;
        count    <= count + CNT_W'(1);
        if (first) begin
          mode_min    <= find_min;
          mode_signed <= is_signed;
        end
        if (frame_end) begin
          out_value <= new_best;
          out_index <= new_idx;
          out_count <= count + CNT_W'(1);
        end
      end
      // Result registers stay untouched here so they hold through ACCUM.
      if (out_valid && out_ready)
        count <= '0;
    end
  end

endmodule

// File: tb/tb_stream_extremum.sv
// tb/tb_stream_extremum.sv - directed and randomised self-checking bench for stream_extremum
module tb_stream_extremum;

  logic       clk = 1'b0;
  logic       rst_n, in_valid, in_ready, in_last, find_min, is_signed;
  logic       out_valid, out_ready;
  logic [7:0] in_data, out_value;
  logic [3:0] out_index;
  logic [4:0] out_count;

  int n_tests = 0;
  int n_fail  = 0;
  logic [7:0] fr [0:15];

  always #5 clk = ~clk;

  stream_extremum #(.WIDTH(8), .LEN(16)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .in_last(in_last), .find_min(find_min), .is_signed(is_signed),
    .out_valid(out_valid), .out_ready(out_ready), .out_value(out_value),
    .out_index(out_index), .out_count(out_count)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [7:0] d, input logic last, input logic fmin,
                      input logic sgn, input bit stall);
    bit rdy;
    int guard = 0;
    if (stall && $urandom_range(0, 2) == 0) begin
      in_valid = 1'b0;
      repeat ($urandom_range(1, 3)) tick();
    end
    in_valid = 1'b1; in_data = d; in_last = last; find_min = fmin; is_signed = sgn;
    do begin
      rdy = in_ready;
      tick();
      guard++;
    end while (!rdy && guard < 50);
    if (!rdy) check("push_timeout", 0, 1);
    in_valid = 1'b0; in_last = 1'b0;
  endtask

  task automatic run_frame(input int n, input bit fmin, input bit sgn, input bit use_last,
                           input bit toggle, input bit stall);
    for (int i = 0; i < n; i++)
      push(fr[i], use_last && (i == n - 1), (i > 0 && toggle) ? ~fmin : fmin, sgn, stall);
  endtask

  task automatic expect_result(input string tag, input logic [7:0] v, input int idx,
                               input int cnt, input int bp);
    int guard = 0;
    while (!out_valid && guard < 50) begin tick(); guard++; end
    check({tag, "_valid"}, out_valid, 1);
    check({tag, "_value"}, out_value, v);
    check({tag, "_index"}, out_index, idx);
    check({tag, "_count"}, out_count, cnt);
    repeat (bp) begin
      tick();
      check({tag, "_bp_valid"}, out_valid, 1);
      check({tag, "_bp_ready"}, in_ready, 0);
      check({tag, "_bp_value"}, out_value, v);
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check({tag, "_drop"}, out_valid, 0);
    check({tag, "_ready"}, in_ready, 1);
  endtask

  function automatic void model(input int n, input bit fmin, input bit sgn,
                                output logic [7:0] v, output int idx);
    int bv, cv;
    bv = 0; v = 8'h00; idx = 0;
    for (int i = 0; i < n; i++) begin
      cv = sgn ? int'($signed(fr[i])) : int'(fr[i]);
      if (i == 0 || (fmin ? (cv < bv) : (cv > bv))) begin
        bv = cv; v = fr[i]; idx = i;
      end
    end
  endfunction

  task automatic load4(input logic [7:0] a, b, c, d);
    fr[0] = a; fr[1] = b; fr[2] = c; fr[3] = d;
  endtask

  initial begin
    logic [7:0] ev;
    int ei, n;
    bit fm, sg, ul;
    rst_n = 1'b0; in_valid = 1'b0; in_data = '0; in_last = 1'b0;
    find_min = 1'b0; is_signed = 1'b0; out_ready = 1'b0;
    repeat (2) tick();
    check("rst_in_ready", in_ready, 1);
    check("rst_out_valid", out_valid, 0);
    check("rst_value", out_value, 0);
    check("rst_index", out_index, 0);
    check("rst_count", out_count, 0);
    rst_n = 1'b1;
    tick();

    load4(8'h05, 8'h80, 8'h7F, 8'h10);
    run_frame(4, 0, 1, 1, 0, 0);
    check("smax_latency", out_valid, 1);
    expect_result("smax", 8'h7F, 2, 4, 0);
    run_frame(4, 0, 0, 1, 0, 0);
    expect_result("umax", 8'h80, 1, 4, 0);
    run_frame(4, 1, 1, 1, 0, 0);
    expect_result("smin", 8'h80, 1, 4, 0);
    run_frame(4, 1, 0, 1, 0, 0);
    expect_result("umin", 8'h05, 0, 4, 0);

    load4(8'h03, 8'h09, 8'h09, 8'h01);
    run_frame(4, 0, 1, 1, 0, 0);
    expect_result("tie", 8'h09, 1, 4, 0);

    for (int i = 0; i < 16; i++) fr[i] = 8'(i * 3 + 1);
    run_frame(16, 0, 0, 0, 0, 0);
    check("full_in_ready", in_ready, 0);
    expect_result("full", 8'd46, 15, 16, 0);
    run_frame(16, 1, 0, 1, 0, 0);
    check("full_last_in_ready", in_ready, 0);
    expect_result("full_last", 8'd1, 0, 16, 0);
    tick();
    check("full_last_single_end", out_valid, 0);

    load4(8'h05, 8'h80, 8'h7F, 8'h10);
    run_frame(4, 0, 1, 1, 1, 0);
    in_valid = 1'b1; in_data = 8'h7E; in_last = 1'b1;
    expect_result("bp_toggle", 8'h7F, 2, 4, 5);
    in_valid = 1'b0; in_last = 1'b0;
    check("bp_no_accept", out_valid, 0);

    fr[0] = 8'hFF;
    run_frame(1, 0, 1, 1, 0, 0);
    expect_result("single", 8'hFF, 0, 1, 0);

    load4(8'h7F, 8'h7E, 8'h00, 8'h00);
    run_frame(2, 0, 1, 0, 0, 0);
    rst_n = 1'b0; tick(); rst_n = 1'b1;
    fr[0] = 8'h01;
    run_frame(1, 0, 1, 1, 0, 0);
    expect_result("midreset", 8'h01, 0, 1, 0);

    for (int f = 0; f < 10; f++) begin
      n = $urandom_range(1, 16);
      fm = 1'($urandom_range(0, 1));
      sg = 1'($urandom_range(0, 1));
      ul = (n < 16) ? 1'b1 : 1'($urandom_range(0, 1));
      for (int i = 0; i < n; i++) fr[i] = 8'($urandom_range(0, 255));
      if (f == 0) fr[n - 1] = fr[0];
      model(n, fm, sg, ev, ei);
      run_frame(n, fm, sg, ul, 0, 1);
      expect_result($sformatf("rnd%0d", f), ev, ei, n, $urandom_range(0, 3));
    end

    load4(8'h22, 8'h11, 8'h00, 8'h00);
    run_frame(2, 0, 0, 1, 0, 0);
    check("hold_before_rst", out_valid, 1);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    check("hrst_valid", out_valid, 0);
    check("hrst_ready", in_ready, 1);
    check("hrst_value", out_value, 0);
    check("hrst_index", out_index, 0);
    check("hrst_count", out_count, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
